// File: rtl/multibank_sample_buffer_pkg.sv
// Shared constants for the multi-bank ADC sample buffer.
// Width helper, output format codes, drop counter ceiling.
package multibank_sample_buffer_pkg;

  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_BANK_DEPTH = 8192;

  localparam int OUT_FMT_UNSIGNED = 0;
  localparam int OUT_FMT_SIGNED   = 1;

  localparam logic [15:0] DROP_SAT = 16'hFFFF;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multibank_sample_buffer_toggle_sync.sv
// Two-flop toggle synchroniser with an edge-detect stage.
// pulse is high for one destination cycle per input toggle.
module toggle_sync (
  input  logic clk,
  input  logic nReset,
  input  logic toggleIn,
  output logic pulse
);

  logic [2:0] sync;

  // shift the toggle through two sync flops plus a history flop
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) sync <= '0;
    else         sync <= {sync[1:0], toggleIn};
  end

  assign pulse = sync[2] ^ sync[1];

endmodule

// File: rtl/multibank_sample_buffer.sv
// N-bank round-robin ADC sample buffer feeding the FX3 read side.
// Full banks are handed over whole; overflow drops new samples.
module multibank_sample_buffer
  import multibank_sample_buffer_pkg::*;
#(
  parameter int DATA_WIDTH    = 10,
  parameter int OUT_WIDTH     = 16,
  parameter int BANK_DEPTH    = DEF_BANK_DEPTH,
  parameter int NUM_BANKS     = DEF_NUM_BANKS,
  parameter int OUT_SIGNED    = OUT_FMT_UNSIGNED,
  parameter int OVERFLOW_HOLD = 1000
) (
  input  logic                  writeClock,
  input  logic                  nReset,
  input  logic                  readClock,
  input  logic                  isWriting,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  isReading,
  output logic                  dataAvailable,
  output logic [OUT_WIDTH-1:0]  dataOut,
  output logic                  bufferOverflow,
  output logic [15:0]           droppedCount
);

  localparam int BANK_W  = idxWidth(NUM_BANKS);
  localparam int OFF_W   = idxWidth(BANK_DEPTH);
  localparam int ADDR_W  = BANK_W + OFF_W;
  localparam int HOLD_W  = $clog2(OVERFLOW_HOLD + 1);
  localparam int AVAIL_W = $clog2(NUM_BANKS + 1);

  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [OFF_W-1:0]  LAST_OFF  = OFF_W'(BANK_DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LD   = HOLD_W'(OVERFLOW_HOLD);

  logic [DATA_WIDTH-1:0] ram [NUM_BANKS*BANK_DEPTH];

  logic [BANK_W-1:0]    wrBank;
  logic [OFF_W-1:0]     wrAddr;
  logic [NUM_BANKS-1:0] bankFull;
  logic                 wrDoneToggle;
  logic [BANK_W-1:0]    relBank;
  logic                 relPulse;
  logic [HOLD_W-1:0]    holdCnt;
  logic                 wrAccept;
  logic                 wrDrop;
  logic                 wrLast;
  logic [ADDR_W-1:0]    wrPtr;

  logic [BANK_W-1:0]    rdBank;
  logic [OFF_W-1:0]     rdAddr;
  logic [AVAIL_W-1:0]   availCount;
  logic [AVAIL_W-1:0]   availNext;
  logic                 rdRelToggle;
  logic                 doneTick;
  logic                 rdFire;
  logic                 rdLast;
  logic [ADDR_W-1:0]    rdPtr;

  function automatic logic [OUT_WIDTH-1:0] widen(
    input logic [DATA_WIDTH-1:0] s
  );
    logic [DATA_WIDTH-1:0] t;
    t = s;
    t[DATA_WIDTH-1] = ~s[DATA_WIDTH-1];
    if (OUT_SIGNED == OUT_FMT_SIGNED) return OUT_WIDTH'($signed(t));
    return OUT_WIDTH'(s);
  endfunction

  assign wrAccept = isWriting && !bankFull[wrBank];
  assign wrDrop   = isWriting && bankFull[wrBank];
  assign wrLast   = wrAccept && (wrAddr == LAST_OFF);
  assign wrPtr    = {wrBank, wrAddr};

  assign rdFire = isReading && dataAvailable;
  assign rdLast = rdFire && (rdAddr == LAST_OFF);
  assign rdPtr  = {rdBank, rdAddr};

  toggle_sync relSync (
    .clk      (writeClock),
    .nReset   (nReset),
    .toggleIn (rdRelToggle),
    .pulse    (relPulse)
  );

  toggle_sync doneSync (
    .clk      (readClock),
    .nReset   (nReset),
    .toggleIn (wrDoneToggle),
    .pulse    (doneTick)
  );

  // sample storage, written from the ADC side only
  always_ff @(posedge writeClock) begin
    if (wrAccept) ram[wrPtr] <= dataIn;
  end

  // write pointer, bank ownership and in-order release
  always_ff @(posedge writeClock or negedge nReset) begin
    if (!nReset) begin
      wrBank       <= '0;
      wrAddr       <= '0;
      bankFull     <= '0;
      wrDoneToggle <= 1'b0;
      relBank      <= '0;
    end else begin
      if (relPulse) begin
        bankFull[relBank] <= 1'b0;
        relBank <= (relBank == LAST_BANK) ? '0 : relBank + 1'b1;
      end
      if (wrAccept) begin
        wrAddr <= wrAddr + 1'b1;
        if (wrLast) begin
          bankFull[wrBank] <= 1'b1;
          wrDoneToggle     <= ~wrDoneToggle;
          wrBank <= (wrBank == LAST_BANK) ? '0 : wrBank + 1'b1;
        end
      end
    end
  end

  // drop counting and stretched overflow flag
  always_ff @(posedge writeClock or negedge nReset) begin
    if (!nReset) begin
      holdCnt        <= '0;
      bufferOverflow <= 1'b0;
      droppedCount   <= '0;
    end else begin
      bufferOverflow <= wrDrop || (holdCnt > HOLD_W'(1));
      if (wrDrop) begin
        holdCnt <= HOLD_LD;
        if (droppedCount != DROP_SAT) droppedCount <= droppedCount + 1'b1;
      end else if (holdCnt != '0) begin
        holdCnt <= holdCnt - 1'b1;
      end
    end
  end

  // completed-bank count; increment and decrement cancel
  always_comb begin
    availNext = availCount + AVAIL_W'(doneTick) - AVAIL_W'(rdLast);
  end

  // read pointer, registered data and release toggle
  always_ff @(posedge readClock or negedge nReset) begin
    if (!nReset) begin
      rdBank        <= '0;
      rdAddr        <= '0;
      availCount    <= '0;
      dataAvailable <= 1'b0;
      rdRelToggle   <= 1'b0;
      dataOut       <= '0;
    end else begin
      availCount    <= availNext;
      dataAvailable <= (availNext != '0);
      if (rdFire) begin
        dataOut <= widen(ram[rdPtr]);
        rdAddr  <= rdAddr + 1'b1;
        if (rdLast) begin
          rdRelToggle <= ~rdRelToggle;
          rdBank <= (rdBank == LAST_BANK) ? '0 : rdBank + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multibank_sample_buffer.sv
// Scoreboard bench for multibank_sample_buffer, 3 banks of 16.
// An unsigned and a signed instance share all stimulus.
module tb_multibank_sample_buffer;

  localparam int DW   = 10;
  localparam int OW   = 16;
  localparam int BD   = 16;
  localparam int NB   = 3;
  localparam int HOLD = 20;

  typedef struct packed {
    logic [15:0] u;
    logic [15:0] s;
  } exp_t;

  logic          writeClock = 1'b0;
  logic          readClock  = 1'b0;
  logic          nReset     = 1'b0;
  logic          isWriting  = 1'b0;
  logic          isReading  = 1'b0;
  logic [DW-1:0] dataIn     = '0;

  logic          dataAvailable, dataAvailableS;
  logic          bufferOverflow, bufferOverflowS;
  logic [OW-1:0] dataOut, dataOutS;
  logic [15:0]   droppedCount, droppedCountS;

  exp_t expQ[$];
  int checks   = 0;
  int failures = 0;
  int rxCount  = 0;

  always #13 writeClock = ~writeClock;
  always #5  readClock  = ~readClock;

  multibank_sample_buffer #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .BANK_DEPTH(BD),
    .NUM_BANKS(NB), .OUT_SIGNED(0), .OVERFLOW_HOLD(HOLD)
  ) dut (
    .writeClock(writeClock), .nReset(nReset),
    .readClock(readClock), .isWriting(isWriting),
    .dataIn(dataIn), .isReading(isReading),
    .dataAvailable(dataAvailable), .dataOut(dataOut),
    .bufferOverflow(bufferOverflow),
    .droppedCount(droppedCount)
  );

  multibank_sample_buffer #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .BANK_DEPTH(BD),
    .NUM_BANKS(NB), .OUT_SIGNED(1), .OVERFLOW_HOLD(HOLD)
  ) dutS (
    .writeClock(writeClock), .nReset(nReset),
    .readClock(readClock), .isWriting(isWriting),
    .dataIn(dataIn), .isReading(isReading),
    .dataAvailable(dataAvailableS), .dataOut(dataOutS),
    .bufferOverflow(bufferOverflowS),
    .droppedCount(droppedCountS)
  );

  function automatic logic [15:0] sconv(input logic [DW-1:0] d);
    logic [DW-1:0] t;
    t = d ^ 10'h200;
    return {{(OW-DW){t[DW-1]}}, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic writeExp(input logic [DW-1:0] d,
                          input logic [15:0] u, input logic [15:0] s);
    exp_t e;
    @(negedge writeClock);
    isWriting = 1'b1;
    dataIn    = d;
    e.u = u;
    e.s = s;
    expQ.push_back(e);
  endtask

  task automatic writeOne(input logic [DW-1:0] d, input bit accept);
    if (accept) begin
      writeExp(d, OW'(d), sconv(d));
    end else begin
      @(negedge writeClock);
      isWriting = 1'b1;
      dataIn    = d;
    end
  endtask

  task automatic idleWrite();
    @(negedge writeClock);
    isWriting = 1'b0;
  endtask

  task automatic readN(input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < n * 20 + 100) begin
      @(negedge readClock);
      isReading = 1'b1;
      @(posedge readClock);
      if (dataAvailable) got++;
      cyc++;
    end
    @(negedge readClock);
    isReading = 1'b0;
    chk("read_count", got, n);
  endtask

  task automatic waitAvail(input string name);
    int cyc = 0;
    while (!dataAvailable && cyc < 30) begin
      @(posedge readClock);
      #1;
      cyc++;
    end
    chk(name, {31'd0, dataAvailable}, 1);
  endtask

  // monitor: every accepted read shows its word one cycle later
  initial begin
    exp_t e;
    forever begin
      @(posedge readClock);
      if (nReset && isReading && dataAvailable) begin
        #2;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_read actual=%0h required=none", dataOut);
        end else begin
          e = expQ.pop_front();
          chk("dataOut", dataOut, e.u);
          chk("dataOutSigned", dataOutS, e.s);
        end
        rxCount++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cyc;
    repeat (3) @(negedge writeClock);
    #1;
    chk("rst_avail", {31'd0, dataAvailable}, 0);
    chk("rst_dataOut", dataOut, 0);
    chk("rst_overflow", {31'd0, bufferOverflow}, 0);
    chk("rst_dropped", droppedCount, 0);
    chk("rst_dropped_s", droppedCountS, 0);
    @(negedge writeClock);
    nReset = 1'b1;

    // ramp 0..47 into three banks, then drain
    for (int i = 0; i < 15; i++) writeOne(DW'(i), 1'b1);
    idleWrite();
    repeat (8) @(posedge readClock);
    #1;
    chk("avail_partial", {31'd0, dataAvailable}, 0);
    writeOne(DW'(15), 1'b1);
    idleWrite();
    waitAvail("avail_first_bank");
    for (int i = 16; i < 48; i++) writeOne(DW'(i), 1'b1);
    idleWrite();
    readN(48);
    repeat (10) @(posedge writeClock);
    #1;
    chk("t1_queue_empty", expQ.size(), 0);
    chk("t1_avail_low", {31'd0, dataAvailable}, 0);

    // idle reader: 48 stored, 12 dropped
    for (int i = 0; i < 60; i++) writeOne(DW'(100 + i), i < 48);
    idleWrite();
    chk("ovf_set", {31'd0, bufferOverflow}, 1);
    chk("ovf_dropped", droppedCount, 12);
    repeat (HOLD - 1) @(negedge writeClock);
    chk("ovf_hold_end", {31'd0, bufferOverflow}, 1);
    @(negedge writeClock);
    chk("ovf_cleared", {31'd0, bufferOverflowS}, 0);
    chk("ovf_cleared_u", {31'd0, bufferOverflow}, 0);

    // release one bank, refill it from offset 0
    readN(16);
    repeat (10) @(posedge writeClock);
    for (int i = 0; i < 16; i++) writeOne(DW'(200 + i), 1'b1);
    idleWrite();
    readN(48);
    repeat (10) @(posedge writeClock);
    #1;
    chk("t3_queue_empty", expQ.size(), 0);
    chk("t3_dropped", droppedCount, 12);

    // hand-computed signed conversion corners
    writeExp(10'h000, 16'h0000, 16'hFE00);
    writeExp(10'h200, 16'h0200, 16'h0000);
    writeExp(10'h3FF, 16'h03FF, 16'h01FF);
    for (int i = 0; i < 13; i++) writeOne(DW'(300 + i), 1'b1);
    idleWrite();
    waitAvail("avail_signed");
    readN(16);
    repeat (10) @(posedge writeClock);

    // reset with one full bank and half a bank pending
    for (int i = 0; i < 24; i++) writeOne(DW'(400 + i), 1'b1);
    idleWrite();
    waitAvail("avail_prereset");
    @(negedge writeClock);
    nReset = 1'b0;
    #2;
    chk("mid_rst_avail", {31'd0, dataAvailable}, 0);
    chk("mid_rst_dataOut", dataOut, 0);
    chk("mid_rst_overflow", {31'd0, bufferOverflow}, 0);
    chk("mid_rst_dropped", droppedCount, 0);
    expQ.delete();
    repeat (2) @(negedge writeClock);
    nReset = 1'b1;
    for (int i = 0; i < 16; i++) writeOne(DW'(600 + i), 1'b1);
    idleWrite();
    waitAvail("avail_postreset");
    readN(16);
    chk("post_rst_dropped", droppedCount, 0);
    chk("post_rst_queue", expQ.size(), 0);

    // 200 banks with a randomly stalling reader
    base = rxCount;
    cyc  = 0;
    fork
      begin
        for (int i = 0; i < 200 * BD; i++)
          writeOne(DW'((i * 7 + 3) % 1024), 1'b1);
        idleWrite();
      end
      begin
        while (rxCount - base < 200 * BD && cyc < 20000) begin
          @(negedge readClock);
          isReading = ($urandom_range(0, 3) != 0);
          cyc++;
        end
        @(negedge readClock);
        isReading = 1'b0;
      end
    join
    chk("rand_count", rxCount - base, 200 * BD);
    chk("rand_dropped", droppedCount, 0);
    chk("rand_queue", expQ.size(), 0);
    chk("rand_overflow", {31'd0, bufferOverflow}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
